// File: rtl/us_drive_ctrl.sv
// us_drive_ctrl: ramps a transducer drive level toward a commanded target, writes each level to the
// DAC over req/ack, and runs a TX pulse burst / RX listen window. Optional macro: AUTO_LISTEN_EN.
module us_drive_ctrl #(
  parameter int unsigned AMOUNT_WIDTH = 8,
  parameter int unsigned DAC_WIDTH    = 12,
  parameter int unsigned LEVEL_MAX    = 255,
  parameter int unsigned STEP_DIV     = 100,
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned HALF_PER     = 25,
  parameter int unsigned RX_WIN       = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid,
  input  logic                    on,
  input  logic                    off,
  input  logic                    increase,
  input  logic                    decrease,
  input  logic                    send,
  input  logic                    receive,
  input  logic [AMOUNT_WIDTH-1:0] amount,
  output logic [DAC_WIDTH-1:0]    dac_data,
  output logic                    dac_wr,
  input  logic                    dac_ack,
  output logic                    tx_pulse,
  output logic                    rx_gate,
  output logic                    enabled,
  output logic                    busy,
  output logic [AMOUNT_WIDTH-1:0] level,
  output logic                    cmd_drop
);

  localparam int unsigned SHIFT   = DAC_WIDTH - AMOUNT_WIDTH;
  localparam int unsigned STEP_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned ACT_MAX = (RX_WIN > HALF_PER) ? RX_WIN : HALF_PER;
  localparam int unsigned ACT_W   = (ACT_MAX > 1) ? $clog2(ACT_MAX) : 1;
  localparam int unsigned HALVES  = 2 * BURST_LEN;
  localparam int unsigned HALF_W  = (HALVES > 1) ? $clog2(HALVES) : 1;
  localparam logic [AMOUNT_WIDTH-1:0] LVL_MAX = AMOUNT_WIDTH'(LEVEL_MAX);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1, S_LISTEN = 2'd2} state_t;

  state_t                  state, state_d;
  logic [AMOUNT_WIDTH-1:0] target, target_d, level_d;
  logic [AMOUNT_WIDTH:0]   sum;
  logic [STEP_W-1:0]       step_cnt, step_cnt_d;
  logic [ACT_W-1:0]        act_cnt, act_cnt_d;
  logic [HALF_W-1:0]       half_cnt, half_cnt_d;
  logic                    off_pend, off_pend_d, enabled_d;
  logic                    dac_wr_d, tx_d, rx_d, drop_d;
  logic [DAC_WIDTH-1:0]    dac_data_d;
  logic                    cmd_off, cmd_on, cmd_dec, cmd_inc, cmd_send, cmd_rcv;

  // One command per cycle, highest priority strobe wins
  always_comb begin
    cmd_off  = valid & off;
    cmd_on   = valid & on & ~off;
    cmd_dec  = valid & decrease & ~off & ~on;
    cmd_inc  = valid & increase & ~off & ~on & ~decrease;
    cmd_send = valid & send & ~off & ~on & ~decrease & ~increase;
    cmd_rcv  = valid & receive & ~off & ~on & ~decrease & ~increase & ~send;
  end

  // Target, enable and reject handling
  always_comb begin
    sum        = {1'b0, target} + {1'b0, amount};
    target_d   = target;
    enabled_d  = enabled;
    off_pend_d = off_pend;
    drop_d     = ((cmd_inc | cmd_dec | cmd_send | cmd_rcv) & ~enabled) |
                 ((cmd_send | cmd_rcv) & enabled & (state != S_IDLE));
    if (cmd_off) begin
      target_d   = '0;
      off_pend_d = 1'b1;
    end else if (cmd_on) begin
      target_d = (amount > LVL_MAX) ? LVL_MAX : amount;
    end else if (cmd_inc && enabled) begin
      target_d = (sum > {1'b0, LVL_MAX}) ? LVL_MAX : sum[AMOUNT_WIDTH-1:0];
    end else if (cmd_dec && enabled) begin
      target_d = (amount >= target) ? '0 : target - amount;
    end
    if (cmd_on) begin
      enabled_d  = 1'b1;
      off_pend_d = 1'b0;
    end else if (off_pend && level == '0 && target == '0 && !dac_wr) begin
      // drive has fully wound down and the last DAC write has been accepted
      enabled_d  = 1'b0;
      off_pend_d = 1'b0;
    end
  end

  // Ramp toward target, stalled while a DAC write is outstanding
  always_comb begin
    level_d    = level;
    step_cnt_d = step_cnt;
    if (level == target) begin
      step_cnt_d = '0;
    end else if (!dac_wr) begin
      if (step_cnt == STEP_W'(STEP_DIV - 1)) begin
        step_cnt_d = '0;
        level_d    = (level < target) ? level + AMOUNT_WIDTH'(1) : level - AMOUNT_WIDTH'(1);
      end else begin
        step_cnt_d = step_cnt + STEP_W'(1);
      end
    end
    dac_wr_d   = dac_wr;
    dac_data_d = dac_data;
    if (level_d != level) begin
      dac_wr_d   = 1'b1;
      dac_data_d = DAC_WIDTH'(level_d) << SHIFT;
    end else if (dac_wr && dac_ack) begin
      dac_wr_d = 1'b0;
    end
  end

  // Burst / listen FSM next state
  always_comb begin
    state_d    = state;
    tx_d       = tx_pulse;
    rx_d       = rx_gate;
    act_cnt_d  = act_cnt;
    half_cnt_d = half_cnt;
    if (cmd_off) begin
      state_d    = S_IDLE;
      tx_d       = 1'b0;
      rx_d       = 1'b0;
      act_cnt_d  = '0;
      half_cnt_d = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_send && enabled) begin
            state_d    = S_BURST;
            tx_d       = 1'b1;
            act_cnt_d  = '0;
            half_cnt_d = '0;
          end else if (cmd_rcv && enabled) begin
            state_d   = S_LISTEN;
            rx_d      = 1'b1;
            act_cnt_d = '0;
          end
        end
        S_BURST: begin
          if (act_cnt == ACT_W'(HALF_PER - 1)) begin
            act_cnt_d = '0;
            if (half_cnt == HALF_W'(HALVES - 1)) begin
              tx_d       = 1'b0;
              half_cnt_d = '0;
`ifdef AUTO_LISTEN_EN
              state_d = S_LISTEN;
              rx_d    = 1'b1;
`else
              state_d = S_IDLE;
`endif
            end else begin
              half_cnt_d = half_cnt + HALF_W'(1);
              tx_d       = ~tx_pulse;
            end
          end else begin
            act_cnt_d = act_cnt + ACT_W'(1);
          end
        end
        S_LISTEN: begin
          if (act_cnt == ACT_W'(RX_WIN - 1)) begin
            state_d   = S_IDLE;
            rx_d      = 1'b0;
            act_cnt_d = '0;
          end else begin
            act_cnt_d = act_cnt + ACT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      target   <= '0;
      level    <= '0;
      step_cnt <= '0;
      act_cnt  <= '0;
      half_cnt <= '0;
      off_pend <= 1'b0;
      enabled  <= 1'b0;
      dac_wr   <= 1'b0;
      dac_data <= '0;
      tx_pulse <= 1'b0;
      rx_gate  <= 1'b0;
      busy     <= 1'b0;
      cmd_drop <= 1'b0;
    end else begin
      state    <= state_d;
      target   <= target_d;
      level    <= level_d;
      step_cnt <= step_cnt_d;
      act_cnt  <= act_cnt_d;
      half_cnt <= half_cnt_d;
      off_pend <= off_pend_d;
      enabled  <= enabled_d;
      dac_wr   <= dac_wr_d;
      dac_data <= dac_data_d;
      tx_pulse <= tx_d;
      rx_gate  <= rx_d;
      busy     <= (state_d != S_IDLE);
      cmd_drop <= drop_d;
    end
  end

endmodule
